// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between num_cores_p cores.
// One transaction in flight at a time; a sticky error flags a response that never arrives.
module dmem_arbiter #(
  parameter int num_cores_p  = 2,
  parameter int addr_width_p = 32,
  parameter int timeout_p    = 255,
  localparam int OW = (num_cores_p > 1) ? $clog2(num_cores_p) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [num_cores_p-1:0]              core_valid_i,
  input  logic [num_cores_p-1:0]              core_wen_i,
  input  logic [num_cores_p-1:0]              core_byte_i,
  input  logic [num_cores_p*addr_width_p-1:0] core_addr_i,
  input  logic [num_cores_p*32-1:0]           core_wdata_i,
  input  logic [num_cores_p-1:0]              core_yumi_i,
  output logic [num_cores_p-1:0]              core_yumi_o,
  output logic [num_cores_p-1:0]              core_valid_o,
  output logic [31:0]                         core_rdata_o,
  output logic                                mem_valid_o,
  output logic                                mem_wen_o,
  output logic                                mem_byte_o,
  output logic [addr_width_p-1:0]             mem_addr_o,
  output logic [31:0]                         mem_wdata_o,
  output logic                                mem_yumi_o,
  input  logic                                mem_yumi_i,
  input  logic                                mem_valid_i,
  input  logic [31:0]                         mem_rdata_i,
  output logic [OW-1:0]                       owner_o,
  output logic                                busy_o,
  output logic                                error_o
);
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  state_e        state_r, state_n;
  logic [OW-1:0] owner_r, owner_n, last_r, last_n, grant, idx;
  logic [7:0]    timer_r, timer_n;
  logic          err_r, err_n, found;
  logic          own_valid, own_yumi;

  assign own_valid = core_valid_i[owner_r];
  assign own_yumi  = core_yumi_i[owner_r];

  // First requester after the last served core wins.
  always_comb begin
    grant = last_r;
    found = 1'b0;
    idx   = '0;
    for (int i = 1; i <= num_cores_p; i++) begin
      idx = OW'((int'(last_r) + i) % num_cores_p);
      if (!found && core_valid_i[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  always_comb begin
    state_n = state_r;
    owner_n = owner_r;
    last_n  = last_r;
    timer_n = timer_r;
    err_n   = err_r;
    case (state_r)
      IDLE: if (|core_valid_i) begin
        owner_n = grant;
        state_n = REQ;
      end
      REQ: begin
        if (mem_yumi_i) begin
          timer_n = '0;
          if (mem_valid_i && own_yumi) begin
            state_n = IDLE;
            last_n  = owner_r;
          end else begin
            state_n = RESP;
          end
        end else if (!own_valid) begin
          state_n = IDLE;
          last_n  = owner_r;
        end
      end
      RESP: begin
        if (mem_valid_i && own_yumi) begin
          state_n = IDLE;
          last_n  = owner_r;
        end else if (timer_r == 8'(timeout_p)) begin
          err_n   = 1'b1;
          state_n = IDLE;
          last_n  = owner_r;
        end else begin
          timer_n = timer_r + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      owner_r <= '0;
      last_r  <= OW'(num_cores_p - 1);
      timer_r <= '0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_n;
      owner_r <= owner_n;
      last_r  <= last_n;
      timer_r <= timer_n;
      err_r   <= err_n;
    end
  end

  // A response arriving with the accept is forwarded in REQ as well.
  always_comb begin
    core_yumi_o  = '0;
    core_valid_o = '0;
    mem_valid_o  = 1'b0;
    mem_wen_o    = 1'b0;
    mem_byte_o   = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    mem_yumi_o   = 1'b0;
    if (state_r == REQ) begin
      mem_valid_o           = own_valid;
      mem_wen_o             = core_wen_i[owner_r];
      mem_byte_o            = core_byte_i[owner_r];
      mem_addr_o            = core_addr_i[int'(owner_r)*addr_width_p +: addr_width_p];
      mem_wdata_o           = core_wdata_i[int'(owner_r)*32 +: 32];
      core_yumi_o[owner_r]  = mem_yumi_i;
      core_valid_o[owner_r] = mem_yumi_i & mem_valid_i;
      mem_yumi_o            = mem_yumi_i & own_yumi;
    end else if (state_r == RESP) begin
      core_valid_o[owner_r] = mem_valid_i;
      mem_yumi_o            = own_yumi;
    end
  end

  assign core_rdata_o = mem_rdata_i;
  assign owner_o      = owner_r;
  assign busy_o       = (state_r != IDLE);
  assign error_o      = err_r;
endmodule
